// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling default and
// the sample points used to recover each bit.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int OS_SAMPLE_A    = 7;
  localparam int OS_SAMPLE_B    = 8;
  localparam int OS_DECIDE      = 9;
  localparam int OS_LAST        = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so no false start is seen after reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled majority-vote bit recovery, optional parity and a
// one-deep output register with a valid/ready handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_x16,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
  localparam logic [OS_W-1:0]  OS_A     = OS_W'(OS_SAMPLE_A);
  localparam logic [OS_W-1:0]  OS_B     = OS_W'(OS_SAMPLE_B);
  localparam logic [OS_W-1:0]  OS_D     = OS_W'(OS_DECIDE);
  localparam logic [OS_W-1:0]  OS_END   = OS_W'((OVERSAMPLE == OVERSAMPLE_DEF) ? OS_LAST : OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);

  rx_state_e            r_state;
  rx_state_e            w_state_next;
  logic [OS_W-1:0]      r_os;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_armed;
  logic                 r_samp_a;
  logic                 r_samp_b;
  logic                 r_par_bad;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;
  logic                 w_rxs;
  logic                 w_at_decide;
  logic                 w_at_end;
  logic                 w_bit_maj;
  logic                 w_stop_done;
  logic                 w_good;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rxs)
  );

  assign w_at_decide = tick_x16 && (r_os == OS_D);
  assign w_at_end    = tick_x16 && (r_os == OS_END);
  assign w_bit_maj   = majority3(r_samp_a, r_samp_b, w_rxs);
  assign w_good      = w_stop_done && w_bit_maj && !r_par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // The stop bit is judged at its decision point so the receiver is ready
  // for the next start edge well before the nominal end of the stop bit.
  always_comb begin
    w_state_next = r_state;
    w_stop_done  = 1'b0;
    case (r_state)
      ST_IDLE:   if (tick_x16 && r_armed && !w_rxs) w_state_next = ST_START;
      ST_START:  if (w_at_decide && w_bit_maj) w_state_next = ST_IDLE;
                 else if (w_at_end) w_state_next = ST_DATA;
      ST_DATA:   if (w_at_end && (r_bit_idx == LAST_BIT))
                   w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_at_end) w_state_next = ST_STOP;
      ST_STOP: begin
        if (w_at_decide) begin
          w_state_next = ST_IDLE;
          w_stop_done  = 1'b1;
        end
      end
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // The detecting tick counts as os 0, so the counter leaves IDLE already at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os      <= '0;
      r_bit_idx <= '0;
      r_armed   <= 1'b0;
      r_samp_a  <= 1'b1;
      r_samp_b  <= 1'b1;
    end else if (tick_x16) begin
      if (r_state == ST_IDLE)
        r_os <= (w_state_next == ST_START) ? OS_ONE : '0;
      else if ((w_state_next != r_state) || (r_os == OS_END))
        r_os <= '0;
      else
        r_os <= r_os + OS_ONE;

      if (r_state != ST_DATA) r_bit_idx <= '0;
      else if (w_at_end)      r_bit_idx <= r_bit_idx + BIT_ONE;

      if (w_stop_done)                        r_armed <= 1'b0;
      else if ((r_state == ST_IDLE) && w_rxs) r_armed <= 1'b1;

      if (r_os == OS_A) r_samp_a <= w_rxs;
      if (r_os == OS_B) r_samp_b <= w_rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      if ((r_state == ST_DATA) && w_at_decide)
        r_shift <= {w_bit_maj, r_shift[DATA_BITS-1:1]};
      if (r_state == ST_IDLE)
        r_par_bad <= 1'b0;
      else if ((r_state == ST_PARITY) && w_at_decide)
        r_par_bad <= (w_bit_maj != ((^r_shift) ^ PAR_ODD));
    end
  end

  // A consumer accepting in the same clk frees the register for the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= w_stop_done && !w_bit_maj;
      r_parity_err <= w_stop_done && w_bit_maj && r_par_bad;
      r_overrun    <= 1'b0;
      if (w_good) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an 8N1 instance and an 8O1 instance driven
// with directed and random frames, judged against a frame-level outcome model.
module tb_uart_rx;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       tick_x16 = 1'b0;
  logic       rx       = 1'b1;
  logic       rxPar    = 1'b1;
  logic       rxReady  = 1'b1;
  logic [7:0] rxData;
  logic [7:0] rxDataPar;
  logic       rxValid, frameErr, parityErr, overrun, busy;
  logic       rxValidPar, frameErrPar, parityErrPar, overrunPar, busyPar;

  int errorCount = 0;
  int checkCount = 0;
  int feCount = 0, peCount = 0, ovCount = 0;
  int feCountPar = 0, peCountPar = 0, ovCountPar = 0;
  logic [7:0] gotQ[$];
  logic [7:0] gotParQ[$];

  always #10 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_x16   (tick_x16),
    .rx         (rx),
    .rx_ready   (rxReady),
    .rx_data    (rxData),
    .rx_valid   (rxValid),
    .frame_err  (frameErr),
    .parity_err (parityErr),
    .overrun    (overrun),
    .busy       (busy)
  );

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1)) dutPar (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_x16   (tick_x16),
    .rx         (rxPar),
    .rx_ready   (1'b1),
    .rx_data    (rxDataPar),
    .rx_valid   (rxValidPar),
    .frame_err  (frameErrPar),
    .parity_err (parityErrPar),
    .overrun    (overrunPar),
    .busy       (busyPar)
  );

  // Baud generator: one-clk tick every 27 clks.
  initial begin
    forever begin
      repeat (26) @(posedge clk);
      #1 tick_x16 = 1'b1;
      @(posedge clk);
      #1 tick_x16 = 1'b0;
    end
  end

  // Collect consumed bytes and error pulses away from the active edge.
  always @(negedge clk) begin
    if (rxValid && rxReady) gotQ.push_back(rxData);
    if (rxValidPar)         gotParQ.push_back(rxDataPar);
    if (frameErr)     feCount++;
    if (parityErr)    peCount++;
    if (overrun)      ovCount++;
    if (frameErrPar)  feCountPar++;
    if (parityErrPar) peCountPar++;
    if (overrunPar)   ovCountPar++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick_x16 !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic setLine(input bit usePar, input logic v);
    if (usePar) rxPar = v;
    else        rx    = v;
  endtask

  // Drives start, data LSB first, optional parity, then the stop bit level.
  task automatic applyStimulus(input bit usePar, input logic [7:0] d, input bit hasPar,
                               input logic parBit, input logic stopBit);
    setLine(usePar, 1'b0);
    waitTicks(16);
    for (int i = 0; i < 8; i++) begin
      setLine(usePar, d[i]);
      waitTicks(16);
    end
    if (hasPar) begin
      setLine(usePar, parBit);
      waitTicks(16);
    end
    setLine(usePar, stopBit);
    waitTicks(16);
  endtask

  // Reference model: 0 = good byte, 1 = frame error, 2 = parity error.
  // The parity instance uses odd parity: data ones plus parity bit must be odd.
  function automatic int expectOutcome(input logic [7:0] d, input bit hasPar,
                                       input logic parBit, input logic stopBit);
    int ones;
    int wantPar;
    ones    = $countones(d);
    wantPar = ((ones % 2) == 0) ? 1 : 0;
    if (stopBit == 1'b0) return 1;
    if (hasPar && (int'(parBit) != wantPar)) return 2;
    return 0;
  endfunction

  task automatic runFrame(input bit usePar, input logic [7:0] d, input logic parBit,
                          input logic stopBit);
    int fe0, pe0, ov0, outcome, n;
    logic [7:0] got;
    string nm;
    nm  = $sformatf("%s 0x%02h", usePar ? "8O1" : "8N1", d);
    fe0 = usePar ? feCountPar : feCount;
    pe0 = usePar ? peCountPar : peCount;
    ov0 = usePar ? ovCountPar : ovCount;
    outcome = expectOutcome(d, usePar, parBit, stopBit);
    applyStimulus(usePar, d, usePar, parBit, stopBit);
    setLine(usePar, 1'b1);
    waitTicks(2);
    checkOutput({nm, " frame_err"},  (usePar ? feCountPar : feCount) - fe0, (outcome == 1) ? 1 : 0);
    checkOutput({nm, " parity_err"}, (usePar ? peCountPar : peCount) - pe0, (outcome == 2) ? 1 : 0);
    checkOutput({nm, " overrun"},    (usePar ? ovCountPar : ovCount) - ov0, 0);
    checkOutput({nm, " busy"},       usePar ? busyPar : busy, 0);
    n = usePar ? gotParQ.size() : gotQ.size();
    checkOutput({nm, " bytes"}, n, (outcome == 0) ? 1 : 0);
    if (n > 0) begin
      if (usePar) got = gotParQ.pop_front();
      else        got = gotQ.pop_front();
      checkOutput({nm, " rx_data"}, got, d);
    end
  endtask

  initial begin
    int fe0, pe0, ov0;
    logic [7:0] d;
    logic pb, sb;

    // Reset must take effect without a clock edge.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset rx_valid", rxValid, 0);
    checkOutput("reset rx_data", rxData, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset pulses", {frameErr, parityErr, overrun}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    waitTicks(4);

    // Clean 0xA5, with a busy probe partway through the frame.
    fork
      runFrame(1'b0, 8'hA5, 1'b0, 1'b1);
      begin
        waitTicks(40);
        checkOutput("A5 busy mid-frame", busy, 1);
      end
    join

    // Short low glitch: start aborts at its decision point.
    rx = 1'b0;
    waitTicks(3);
    rx = 1'b1;
    waitTicks(4);
    checkOutput("glitch busy in start", busy, 1);
    waitTicks(16);
    checkOutput("glitch busy after abort", busy, 0);
    checkOutput("glitch bytes", gotQ.size(), 0);
    checkOutput("glitch pulses", feCount + peCount + ovCount, 0);

    // Random frames on both instances in parallel.
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          logic [7:0] rd;
          logic rs;
          rd = 8'($urandom);
          rs = ($urandom_range(0, 3) != 0);
          runFrame(1'b0, rd, 1'b0, rs);
        end
      end
      begin
        runFrame(1'b1, 8'h03, 1'b0, 1'b1);
        runFrame(1'b1, 8'h03, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
          logic [7:0] rd;
          logic rp, rs;
          rd = 8'($urandom);
          rp = 1'($urandom_range(0, 1));
          rs = ($urandom_range(0, 3) != 0);
          runFrame(1'b1, rd, rp, rs);
        end
      end
    join

    // Bad stop bit followed by a long break.
    fe0 = feCount;
    applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    waitTicks(20 * 16);
    checkOutput("break frame_err", feCount - fe0, 1);
    checkOutput("break bytes", gotQ.size(), 0);
    checkOutput("break busy", busy, 0);
    rx = 1'b1;
    waitTicks(4);
    runFrame(1'b0, 8'h3C, 1'b0, 1'b1);

    // Consumer stalled: second byte is dropped with an overrun pulse.
    rxReady = 1'b0;
    ov0 = ovCount;
    applyStimulus(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    waitTicks(2);
    checkOutput("stall valid", rxValid, 1);
    checkOutput("stall data", rxData, 8'h11);
    applyStimulus(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    waitTicks(2);
    checkOutput("overrun pulses", ovCount - ov0, 1);
    checkOutput("overrun data kept", rxData, 8'h11);
    checkOutput("overrun valid kept", rxValid, 1);
    rxReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drain valid", rxValid, 0);
    checkOutput("drain bytes", gotQ.size(), 1);
    if (gotQ.size() > 0) checkOutput("drain data", gotQ.pop_front(), 8'h11);

    // Reset in the middle of data bit 4 of 0xFF.
    fe0 = feCount;
    pe0 = peCount;
    ov0 = ovCount;
    d = 8'hFF;
    rx = 1'b0;
    waitTicks(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      waitTicks(16);
    end
    rx = d[4];
    waitTicks(8);
    checkOutput("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #2;
    checkOutput("mid reset busy", busy, 0);
    checkOutput("mid reset rx_valid", rxValid, 0);
    checkOutput("mid reset rx_data", rxData, 0);
    checkOutput("mid reset pulses", {frameErr, parityErr, overrun}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    waitTicks(32);
    checkOutput("after reset pulses", (feCount - fe0) + (peCount - pe0) + (ovCount - ov0), 0);
    checkOutput("after reset bytes", gotQ.size(), 0);
    pb = 1'b0;
    sb = 1'b1;
    runFrame(1'b0, 8'h5A, pb, sb);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (5..9).
REQ-002 Parameter OVERSAMPLE, default 16, tick_x16 pulses per bit period.
REQ-003 Parameter PARITY_EN, default 0, 1 = one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 tick_x16  input  1  one-clk pulse at BAUD*OVERSAMPLE from the baud generator.
REQ-008 rx  input  1  asynchronous serial line; idle high.
REQ-009 rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-010 rx_data  output  DATA_BITS  received byte, LSB first on the line.
REQ-011 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-012 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-013 parity_err  output  1  one-clk pulse: parity mismatch.
REQ-014 overrun  output  1  one-clk pulse: completed byte dropped because rx_valid was still high.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 rx shall pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP; os counter 0..OVERSAMPLE-1 advances only on tick_x16.
REQ-018 Each bit value = majority of rxs sampled on tick_x16 at os counts 7, 8, 9; decided at count 9.
REQ-019 IDLE shall be armed only after rxs has been seen high; armed IDLE with rxs=0 on a tick -> START, that tick is os count 0.
REQ-020 START: majority 1 at count 9 -> IDLE (false start, no outputs); else at count 15 -> DATA, bit index 0.
REQ-021 DATA: shift decided bit in LSB first; after bit DATA_BITS-1 completes -> PARITY if PARITY_EN else STOP.
REQ-022 PARITY: compare decided bit to XOR of data (inverted if PARITY_ODD); record mismatch; at count 15 -> STOP.
REQ-023 STOP: at count 9 -> IDLE (disarmed); majority 0 -> frame_err pulse, byte discarded; parity mismatch -> parity_err pulse, byte discarded; frame_err takes precedence, only one error pulse per frame.
REQ-024 Good frame: byte loaded to rx_data and rx_valid set the clk after the count-9 tick of STOP.
REQ-025 rx_valid clears the clk after rx_valid&&rx_ready; rx_data stable while rx_valid high.
REQ-026 Good frame completing while rx_valid high and rx_ready low -> overrun pulse, rx_data unchanged, new byte dropped.
REQ-027 Good frame completing in the same clk as rx_valid&&rx_ready -> new byte loaded, rx_valid stays high, no overrun.
REQ-028 Line held low (break): exactly one frame_err, then no further activity until rxs returns high.
REQ-029 No state change or sampling on clks without tick_x16.

Reset
REQ-030 rst_n low shall immediately force: state IDLE disarmed, os counter 0, bit index 0, synchronizer flops 1, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, overrun 0, busy 0.
REQ-031 Reset asserted mid-frame shall abandon the frame with no error or valid pulse after release.

Structure
REQ-032 Package uart_pkg shall hold the rx state enum, OVERSAMPLE default, and sample-point constants (7/8/9, 15); shared with future uart_tx.
REQ-033 One sub-module uart_sync2 (2-flop synchronizer, async active-low reset to 1) shall be instantiated for rx.

Verification
REQ-034 Bench: clk 50 MHz, tick_x16 every 27 clks (115200 baud), rx_ready=1 unless stated.
REQ-035 Frame 0xA5, 8N1 -> one rx_valid with rx_data=0xA5, no error pulses, busy low after stop count 9.
REQ-036 rx low for 3 ticks then high -> START aborts at count 9, no rx_valid, no errors, back in IDLE.
REQ-037 Frame 0x3C with stop bit 0, rx then held low 20 bit times -> one frame_err, no rx_valid, no second frame_err until rx high and new start.
REQ-038 rx_ready=0, frames 0x11 then 0x22 -> rx_valid with 0x11, overrun pulse at second frame end, rx_data remains 0x11.
REQ-039 PARITY_EN=1, PARITY_ODD=1, frame 0x03 with parity bit 0 -> parity_err pulse, no rx_valid; parity bit 1 -> rx_data=0x03.
REQ-040 rst_n low during DATA bit 4 of 0xFF -> all outputs 0 immediately; next clean frame 0x5A received correctly.
